elastic_pipe: RTL and testbench
===============================

Name: elastic_pipe

Overview:
- Parametrised successor to the single enable register: a DEPTH-stage elastic pipeline register with a valid/ready handshake at both ends.
- Also provides a per-stage valid bit, bubble collapsing, synchronous flush, a global enable/freeze, a configurable data reset value and an occupancy count.
- Sits between multicycle datapath stages, for example the instruction register to decode path or the memory data register, wherever stall and flush are needed.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 2, number of register stages; must be ≥1.
- RESET_VAL, 0 (WIDTH bits), value loaded into every data stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- en  input  1  global enable; 0 freezes the pipeline.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream has data.
- in_ready  output  1  pipeline accepts data this cycle.
- d  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds data.
- out_ready  input  1  downstream accepts data.
- q  output  WIDTH  data of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State: v[i] and data[i] for i = 0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 is the output side.
- Reset (reset=0, asynchronous): all v=0 and all data=RESET_VAL. This gives out_valid=0, q=RESET_VAL, count=0, in_ready=0 while reset is asserted.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & en & !flush.
- out_valid = v[DEPTH-1] & en & !flush. q = data[DEPTH-1], always driven regardless of valid.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Clock edge when en=1 and flush=0:
  - For each stage i with rdy[i]=1: v[i] takes the incoming valid. For stage 0 this is in_valid; for stage i>0 it is v[i-1].
  - data[i] loads only when the incoming valid is 1; otherwise data[i] holds.
  - A stage with rdy[i]=0 holds both v[i] and data[i].
- Bubble collapsing: an empty stage accepts from upstream even while downstream is stalled. A full pipeline (count=DEPTH) with out_ready=0 gives in_ready=0.
- Latency: an item accepted in cycle t shows out_valid in cycle t+DEPTH when there are no stalls.
- Throughput: one item per cycle sustained.
- Ordering: FIFO. No item is dropped or duplicated except by flush.
- en=0, flush=0: all state holds; in_ready=0 and out_valid=0, so no transfers occur.
- flush=1 (any en): the next edge clears all v; data holds. in_ready and out_valid are forced 0 in the flush cycle, so the in-flight input and output are both discarded. Flush has priority over en.
- count = popcount(v), registered state only. It updates on the edge and is not gated by en or flush.
- Reset asserted mid-stream: all items are lost immediately and the next accepted item sees an empty pipe. Reset release is synchronised externally; no internal synchroniser.
- DEPTH=1: degenerates to a one-entry register with a combinational ready pass-through (in_ready = !v | out_ready).
- The ready path is combinational across DEPTH stages. Integrators must accept the timing path from out_ready to in_ready.

Decomposition:
- No shared package required. The count width uses a local clog2 function or $clog2.
- Natural sub-module: pipe_stage.
  - Parameters: WIDTH, RESET_VAL.
  - Ports: clk, reset, en, flush, vin, din, rdy_next, v, data, rdy.
  - It implements one valid+data register and its rdy term.
- elastic_pipe instantiates DEPTH copies of pipe_stage in a generate loop and computes count.

Test Plan:
1. Reset/idle: reset=0 with d=32'hDEADBEEF, then release (DEPTH=2, RESET_VAL=0) -> q=0, out_valid=0, count=0, in_ready=1 after release.
2. Streaming: out_ready=1, en=1, feed A1..A8 back-to-back from cycle 0 -> out_valid first in cycle 2 with q=A1, then one item per cycle in order, in_ready never drops.
3. Back-pressure and collapse:
   - Hold out_ready=0 and feed B1,B2,B3 -> B1,B2 accepted, count=2, in_ready=0 on B3.
   - Raise out_ready -> B1 out, B3 accepted the same cycle, order B1,B2,B3.
4. Freeze: mid-stream with count=2, drive en=0 for 3 cycles -> in_ready=0, out_valid=0, count and q unchanged. en=1 -> stream resumes with no loss.
5. Flush: count=2 with in_valid=1 and out_ready=1, pulse flush one cycle -> no transfer that cycle, count=0 next cycle. The next input appears DEPTH cycles after acceptance.
6. Async reset mid-stream: drop reset between clock edges with count=2 -> out_valid=0, q=RESET_VAL, count=0 before the next edge.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared defaults and helpers for the elastic pipeline register.
package elastic_pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  // Width needed to hold an occupancy value in 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Valid/ready handshake bundle covering both ends of the elastic pipeline.
interface elastic_pipe_if
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;

  // master: the surrounding datapath; slave: the pipeline itself.
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, q
  );

endinterface

// File: rtl/elastic_pipe_stage.sv
// One valid+data register of the elastic pipeline and its ready term.
module elastic_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy_next,
  output logic             v,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] data_q, data_d;

  // An empty stage always accepts, which is what collapses bubbles.
  assign rdy = !v_q | rdy_next;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (en && rdy) begin
      v_d = vin;
      if (vin) data_d = din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q    <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign v    = v_q;
  assign data = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage elastic pipeline register with stall, flush, freeze and occupancy count.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  elastic_pipe_if.slave bus,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] v_vec;
  logic [WIDTH-1:0] data_arr [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;
    logic             rdy_nxt;
    logic             rdy_s;

    if (i == 0) begin : g_head
      assign vin = bus.in_valid;
      assign din = bus.d;
    end else begin : g_body
      assign vin = v_vec[i-1];
      assign din = data_arr[i-1];
    end

    // Each stage's ready lives in its own net so the chain is not one looped vector.
    if (i == DEPTH - 1) begin : g_tail
      assign rdy_nxt = bus.out_ready;
    end else begin : g_link
      assign rdy_nxt = g_stage[i+1].rdy_s;
    end

    elastic_pipe_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .vin     (vin),
      .din     (din),
      .rdy_next(rdy_nxt),
      .v       (v_vec[i]),
      .data    (data_arr[i]),
      .rdy     (rdy_s)
    );
  end

  // Reset also blocks in_ready so nothing is offered while the pipe is held clear.
  assign bus.in_ready  = g_stage[0].rdy_s & en & !flush & reset;
  assign bus.out_valid = v_vec[DEPTH-1] & en & !flush;
  assign bus.q         = data_arr[DEPTH-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v_vec[i]);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed self-checking bench for elastic_pipe at WIDTH=32, DEPTH=2, RESET_VAL=0.
module tb_elastic_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flush;
  logic [1:0] count;
  int         checks = 0;
  int         passes = 0;

  elastic_pipe_if #(.WIDTH(32)) bus ();

  elastic_pipe #(
    .WIDTH    (32),
    .DEPTH    (2),
    .RESET_VAL(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .flush(flush),
    .bus  (bus),
    .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.d = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.q !== 32'h0) $display("FAIL reset_q: got %h expected 00000000", bus.q); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); else passes++;
    bus.in_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.q !== 32'h0) $display("FAIL idle_q: got %h expected 00000000", bus.q); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (count !== 2'd0) $display("FAIL idle_count: got %0d expected 0", count); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); else passes++;
    next_cycle();
  endtask

  task automatic test_stream();
    logic [31:0] exp_q;
    en = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (k < 8);
      bus.d = 32'hA000_0001 + 32'(k);
      @(negedge clk);
      if (k < 8) begin
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, bus.in_ready); else passes++;
      end
      if (k >= 2) begin
        exp_q = 32'hA000_0001 + 32'(k - 2);
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL stream_out_valid[%0d]: got %b expected 1", k, bus.out_valid); else passes++;
        checks++; if (bus.q !== exp_q) $display("FAIL stream_q[%0d]: got %h expected %h", k, bus.q, exp_q); else passes++;
      end else begin
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_out_valid[%0d]: got %b expected 0", k, bus.out_valid); else passes++;
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (count !== 2'd0) $display("FAIL stream_drain_count: got %0d expected 0", count); else passes++;
    next_cycle();
  endtask

  task automatic test_backpressure();
    en = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.d = 32'hB000_0001;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_b1: got %b expected 1", bus.in_ready); else passes++;
    next_cycle();
    bus.d = 32'hB000_0002;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_b2: got %b expected 1", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_out_valid_b2: got %b expected 0", bus.out_valid); else passes++;
    next_cycle();
    bus.d = 32'hB000_0003;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b expected 0", bus.in_ready); else passes++;
    checks++; if (count !== 2'd2) $display("FAIL bp_count_full: got %0d expected 2", count); else passes++;
    checks++; if (bus.q !== 32'hB000_0001) $display("FAIL bp_q_full: got %h expected b0000001", bus.q); else passes++;
    next_cycle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_release: got %b expected 1", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid_release: got %b expected 1", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'hB000_0001) $display("FAIL bp_q_b1: got %h expected b0000001", bus.q); else passes++;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.q !== 32'hB000_0002) $display("FAIL bp_q_b2: got %h expected b0000002", bus.q); else passes++;
    checks++; if (count !== 2'd2) $display("FAIL bp_count_b2: got %0d expected 2", count); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.q !== 32'hB000_0003) $display("FAIL bp_q_b3: got %h expected b0000003", bus.q); else passes++;
    checks++; if (count !== 2'd1) $display("FAIL bp_count_b3: got %0d expected 1", count); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (count !== 2'd0) $display("FAIL bp_count_empty: got %0d expected 0", count); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_out_valid_empty: got %b expected 0", bus.out_valid); else passes++;
    next_cycle();
  endtask

  task automatic test_freeze();
    en = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.d = 32'hC000_0001;
    next_cycle();
    bus.d = 32'hC000_0002;
    next_cycle();
    en = 1'b0; bus.out_ready = 1'b1; bus.d = 32'hC000_0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) $display("FAIL freeze_in_ready[%0d]: got %b expected 0", k, bus.in_ready); else passes++;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL freeze_out_valid[%0d]: got %b expected 0", k, bus.out_valid); else passes++;
      checks++; if (count !== 2'd2) $display("FAIL freeze_count[%0d]: got %0d expected 2", k, count); else passes++;
      checks++; if (bus.q !== 32'hC000_0001) $display("FAIL freeze_q[%0d]: got %h expected c0000001", k, bus.q); else passes++;
      next_cycle();
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL resume_in_ready: got %b expected 1", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL resume_out_valid: got %b expected 1", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'hC000_0001) $display("FAIL resume_q_c1: got %h expected c0000001", bus.q); else passes++;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.q !== 32'hC000_0002) $display("FAIL resume_q_c2: got %h expected c0000002", bus.q); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.q !== 32'hC000_0003) $display("FAIL resume_q_c3: got %h expected c0000003", bus.q); else passes++;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL resume_out_valid_c3: got %b expected 1", bus.out_valid); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (count !== 2'd0) $display("FAIL resume_count_empty: got %0d expected 0", count); else passes++;
    next_cycle();
  endtask

  task automatic test_flush();
    en = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.d = 32'hD000_0001;
    next_cycle();
    bus.d = 32'hD000_0002;
    next_cycle();
    flush = 1'b1; bus.out_ready = 1'b1; bus.d = 32'hD000_0003;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (count !== 2'd2) $display("FAIL flush_count_pre: got %0d expected 2", count); else passes++;
    next_cycle();
    flush = 1'b0; bus.d = 32'hD000_0004;
    @(negedge clk);
    checks++; if (count !== 2'd0) $display("FAIL flush_count_post: got %0d expected 0", count); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid_post: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'hD000_0001) $display("FAIL flush_q_hold: got %h expected d0000001", bus.q); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready_post: got %b expected 1", bus.in_ready); else passes++;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_lat1_out_valid: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (count !== 2'd1) $display("FAIL flush_lat1_count: got %0d expected 1", count); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_lat2_out_valid: got %b expected 1", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'hD000_0004) $display("FAIL flush_lat2_q: got %h expected d0000004", bus.q); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (count !== 2'd0) $display("FAIL flush_drain_count: got %0d expected 0", count); else passes++;
    next_cycle();
  endtask

  task automatic test_async_reset();
    en = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.d = 32'hE000_0001;
    next_cycle();
    bus.d = 32'hE000_0002;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 2'd2) $display("FAIL areset_count_pre: got %0d expected 2", count); else passes++;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL areset_out_valid: got %b expected 0", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'h0) $display("FAIL areset_q: got %h expected 00000000", bus.q); else passes++;
    checks++; if (count !== 2'd0) $display("FAIL areset_count: got %0d expected 0", count); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL areset_in_ready: got %b expected 0", bus.in_ready); else passes++;
    next_cycle();
    reset = 1'b1; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.d = 32'hE000_0003;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL areset_in_ready_post: got %b expected 1", bus.in_ready); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL areset_out_valid_post: got %b expected 0", bus.out_valid); else passes++;
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 2'd1) $display("FAIL areset_lat1_count: got %0d expected 1", count); else passes++;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL areset_lat2_out_valid: got %b expected 1", bus.out_valid); else passes++;
    checks++; if (bus.q !== 32'hE000_0003) $display("FAIL areset_lat2_q: got %h expected e0000003", bus.q); else passes++;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_freeze();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
